// File: rtl/quad_encoder_multi_pkg.sv
// Shared types and helpers for the multi-channel quadrature encoder decoder.
// Transition tables are indexed by {prev_a, prev_b, curr_a, curr_b}.
package quad_enc_pkg;

  typedef enum logic [1:0] {
    MODE_X1     = 2'd0,
    MODE_X2     = 2'd1,
    MODE_X4     = 2'd2,
    MODE_X4_ALT = 2'd3
  } mode_t;

  // Forward: 00->10, 10->11, 11->01, 01->00. Reverse: 00->01, 01->11, 11->10, 10->00.
  localparam logic [15:0] FWD_LUT = 16'h2814;
  localparam logic [15:0] REV_LUT = 16'h4182;

  // Signed +/-1 at the given bit width, wrapping or clamping at the signed limits.
  function automatic int sat_add(input int val, input logic up, input int width, input logic sat);
    int max_v;
    int min_v;
    int res;
    max_v = (32'sd1 <<< (width - 32'sd1)) - 32'sd1;
    min_v = -(32'sd1 <<< (width - 32'sd1));
    res   = up ? (val + 32'sd1) : (val - 32'sd1);
    if (res > max_v) begin
      res = sat ? max_v : min_v;
    end else if (res < min_v) begin
      res = sat ? min_v : max_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/quad_encoder_multi_if.sv
// Encoder pins, control strobes and per-channel results of quad_encoder_multi.
interface quad_encoder_multi_if
  import quad_enc_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) ();

  logic [N_CH-1:0]       enc_a;
  logic [N_CH-1:0]       enc_b;
  mode_t                 mode;
  logic [N_CH-1:0]       load;
  logic [WIDTH-1:0]      load_val;
  logic [N_CH-1:0]       clr_err;
  logic [N_CH*WIDTH-1:0] pos;
  logic [N_CH-1:0]       step;
  logic [N_CH-1:0]       dir;
  logic [N_CH-1:0]       err;

  modport master (
    output enc_a, enc_b, mode, load, load_val, clr_err,
    input  pos, step, dir, err
  );

  modport slave (
    input  enc_a, enc_b, mode, load, load_val, clr_err,
    output pos, step, dir, err
  );

endinterface

// File: rtl/quad_encoder_multi_channel.sv
// One encoder channel: 2-FF synchroniser, per-bit glitch filter, registered decode
// stage and a position counter with preset load and sticky illegal-transition flag.
module quad_channel
  import quad_enc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 4,
  parameter int SATURATE   = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  mode_t            mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       filt_r;
  logic [1:0]       prev_r;
  logic [CNT_W-1:0] cnt_r [2];

  logic [3:0] idx_s;
  logic       fwd_s;
  logic       rev_s;
  logic       ill_s;
  logic       a_chg_s;
  logic       a_rise_s;
  logic       cnt_en_s;

  logic       dec_cnt_r;
  logic       dec_up_r;
  logic       dec_ill_r;

  logic [WIDTH-1:0] pos_r;
  logic             step_r;
  logic             dir_r;
  logic             err_r;

  // Synchroniser plus independent A/B filters; reset preloads the raw level so no step follows.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_r  <= {enc_a, enc_b};
      sync2_r  <= {enc_a, enc_b};
      filt_r   <= {enc_a, enc_b};
      prev_r   <= {enc_a, enc_b};
      cnt_r[0] <= '0;
      cnt_r[1] <= '0;
    end else begin
      sync1_r <= {enc_a, enc_b};
      sync2_r <= sync1_r;
      prev_r  <= filt_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != filt_r[i]) begin
          if (cnt_r[i] == CNT_LAST) begin
            filt_r[i] <= sync2_r[i];
            cnt_r[i]  <= '0;
          end else begin
            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
          end
        end else begin
          cnt_r[i] <= '0;
        end
      end
    end
  end

  // Classify the filtered transition and decide whether the current mode counts it.
  always_comb begin
    idx_s    = {prev_r, filt_r};
    fwd_s    = FWD_LUT[idx_s];
    rev_s    = REV_LUT[idx_s];
    ill_s    = ((prev_r ^ filt_r) == 2'b11);
    a_chg_s  = prev_r[1] ^ filt_r[1];
    a_rise_s = ~prev_r[1] & filt_r[1];
    cnt_en_s = 1'b0;
    case (mode)
      MODE_X1:     cnt_en_s = (fwd_s | rev_s) & a_rise_s;
      MODE_X2:     cnt_en_s = (fwd_s | rev_s) & a_chg_s;
      MODE_X4:     cnt_en_s = fwd_s | rev_s;
      MODE_X4_ALT: cnt_en_s = fwd_s | rev_s;
      default:     cnt_en_s = fwd_s | rev_s;
    endcase
  end

  // Registered decode stage.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dec_cnt_r <= 1'b0;
      dec_up_r  <= 1'b0;
      dec_ill_r <= 1'b0;
    end else begin
      dec_cnt_r <= cnt_en_s;
      dec_up_r  <= fwd_s;
      dec_ill_r <= ill_s;
    end
  end

  // Counter and flags: load overrides a coincident step, an illegal set overrides clr_err.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pos_r  <= '0;
      step_r <= 1'b0;
      dir_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if (load) begin
        pos_r  <= load_val;
        step_r <= 1'b0;
      end else if (dec_cnt_r) begin
        pos_r  <= WIDTH'(sat_add(int'($signed(pos_r)), dec_up_r, WIDTH, SATURATE != 0));
        step_r <= 1'b1;
        dir_r  <= dec_up_r;
      end else begin
        step_r <= 1'b0;
      end
      if (dec_ill_r) begin
        err_r <= 1'b1;
      end else if (clr_err) begin
        err_r <= 1'b0;
      end
    end
  end

  assign pos  = pos_r;
  assign step = step_r;
  assign dir  = dir_r;
  assign err  = err_r;

endmodule

// File: rtl/quad_encoder_multi.sv
// Multi-channel quadrature decoder top: N_CH independent quad_channel instances
// whose results are packed onto the interface, channel 0 in the low bits.
module quad_encoder_multi
  import quad_enc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 4,
  parameter int SATURATE   = 0
) (
  input logic                 clock,
  input logic                 reset_n,
  quad_encoder_multi_if.slave bus
);

  logic [WIDTH-1:0] pos_s  [N_CH];
  logic             step_s [N_CH];
  logic             dir_s  [N_CH];
  logic             err_s  [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    quad_channel #(
      .WIDTH      (WIDTH),
      .FILTER_LEN (FILTER_LEN),
      .SATURATE   (SATURATE)
    ) u_ch (
      .clock    (clock),
      .reset_n  (reset_n),
      .enc_a    (bus.enc_a[g]),
      .enc_b    (bus.enc_b[g]),
      .mode     (bus.mode),
      .load     (bus.load[g]),
      .load_val (bus.load_val),
      .clr_err  (bus.clr_err[g]),
      .pos      (pos_s[g]),
      .step     (step_s[g]),
      .dir      (dir_s[g]),
      .err      (err_s[g])
    );
  end

  // Pack per-channel registered results onto the bus.
  always_comb begin
    bus.pos  = '0;
    bus.step = '0;
    bus.dir  = '0;
    bus.err  = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.pos[i*WIDTH +: WIDTH] = pos_s[i];
      bus.step[i]               = step_s[i];
      bus.dir[i]                = dir_s[i];
      bus.err[i]                = err_s[i];
    end
  end

endmodule

// File: tb/tb_quad_encoder_multi.sv
// Bench for quad_encoder_multi: a wrapping and a saturating instance share stimulus and are
// checked every cycle against a gray-code phase model, plus directed literal checks.
module tb_quad_encoder_multi;
  import quad_enc_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int FL = 4;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  quad_encoder_multi_if #(.N_CH(N), .WIDTH(W)) bus0 ();
  quad_encoder_multi_if #(.N_CH(N), .WIDTH(W)) bus1 ();

  assign bus1.enc_a    = bus0.enc_a;
  assign bus1.enc_b    = bus0.enc_b;
  assign bus1.mode     = bus0.mode;
  assign bus1.load     = bus0.load;
  assign bus1.load_val = bus0.load_val;
  assign bus1.clr_err  = bus0.clr_err;

  quad_encoder_multi #(.N_CH(N), .WIDTH(W), .FILTER_LEN(FL), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .bus(bus0));
  quad_encoder_multi #(.N_CH(N), .WIDTH(W), .FILTER_LEN(FL), .SATURATE(1)) dut_sat (
    .clock(clock), .reset_n(reset_n), .bus(bus1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] hist    [N][FL+2];
  logic [1:0] mf      [N];
  logic [1:0] mf_last [N];
  bit         d_cnt [N], d_up [N], d_ill [N];
  int         e_pos [N], e_pos_s [N];
  bit         e_step [N], e_dir [N], e_err [N];
  bit         model_ok = 1'b0;

  // position of a level in the forward gray cycle 00,10,11,01
  function automatic int ph(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int wrapw(input int v);
    if (v > 127) return v - 256;
    if (v < -128) return v + 256;
    return v;
  endfunction

  function automatic int clampw(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      for (int ch = 0; ch < N; ch++) begin
        logic [1:0] raw;
        int         delta;
        bit         legal, up, a_chg, a_rise, stable;
        raw = {bus0.enc_a[ch], bus0.enc_b[ch]};
        if (!reset_n) begin
          for (int j = 0; j < FL + 2; j++) hist[ch][j] = raw;
          mf[ch] = raw; mf_last[ch] = raw;
          d_cnt[ch] = 0; d_up[ch] = 0; d_ill[ch] = 0;
          e_pos[ch] = 0; e_pos_s[ch] = 0; e_step[ch] = 0; e_dir[ch] = 0; e_err[ch] = 0;
        end else begin
          if (bus0.load[ch]) begin
            e_pos[ch]   = int'($signed(bus0.load_val));
            e_pos_s[ch] = int'($signed(bus0.load_val));
            e_step[ch]  = 0;
          end else if (d_cnt[ch]) begin
            e_pos[ch]   = wrapw(e_pos[ch] + (d_up[ch] ? 1 : -1));
            e_pos_s[ch] = clampw(e_pos_s[ch] + (d_up[ch] ? 1 : -1));
            e_step[ch]  = 1;
            e_dir[ch]   = d_up[ch];
          end else begin
            e_step[ch] = 0;
          end
          if (d_ill[ch]) e_err[ch] = 1;
          else if (bus0.clr_err[ch]) e_err[ch] = 0;

          delta  = (ph(mf[ch]) - ph(mf_last[ch]) + 4) % 4;
          legal  = (delta == 1) || (delta == 3);
          up     = (delta == 1);
          a_chg  = (mf[ch][1] != mf_last[ch][1]);
          a_rise = !mf_last[ch][1] && mf[ch][1];
          case (int'(bus0.mode))
            0:       d_cnt[ch] = legal && a_rise;
            1:       d_cnt[ch] = legal && a_chg;
            default: d_cnt[ch] = legal;
          endcase
          d_up[ch]    = up;
          d_ill[ch]   = (delta == 2);
          mf_last[ch] = mf[ch];

          // a new level is accepted once FL consecutive synchronised samples show it
          for (int i = 0; i < 2; i++) begin
            stable = 1;
            for (int j = 1; j <= FL; j++)
              if (hist[ch][j][i] != hist[ch][1][i]) stable = 0;
            if (stable && hist[ch][1][i] != mf[ch][i]) mf[ch][i] = hist[ch][1][i];
          end
          for (int j = FL + 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
          hist[ch][0] = raw;
        end
      end
      model_ok = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  int stepcnt = 0;
  initial begin
    forever begin
      logic [N*W-1:0] ep0, ep1;
      logic [N-1:0]   es, ed, ee;
      @(negedge clock);
      if (bus0.step[0] === 1'b1) stepcnt++;
      if (model_ok) begin
        for (int ch = 0; ch < N; ch++) begin
          ep0[ch*W +: W] = W'(e_pos[ch]);
          ep1[ch*W +: W] = W'(e_pos_s[ch]);
          es[ch] = e_step[ch];
          ed[ch] = e_dir[ch];
          ee[ch] = e_err[ch];
        end
        chk("wrap_pos", 64'(bus0.pos), 64'(ep0));
        chk("wrap_step", 64'(bus0.step), 64'(es));
        chk("wrap_dir", 64'(bus0.dir), 64'(ed));
        chk("wrap_err", 64'(bus0.err), 64'(ee));
        chk("sat_pos", 64'(bus1.pos), 64'(ep1));
        chk("sat_step", 64'(bus1.step), 64'(es));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_ab(input logic [1:0] ab);
    for (int ch = 0; ch < N; ch++) begin
      bus0.enc_a[ch] = ab[1];
      bus0.enc_b[ch] = ab[0];
    end
  endtask

  task automatic load_all(input logic [W-1:0] v);
    bus0.load_val = v;
    bus0.load     = '1;
    wait_clk(1);
    bus0.load     = '0;
  endtask

  logic [W-1:0] exp4 [3];
  mode_t        modes [3];
  int           ph_r [N];
  int           hold [N];

  initial begin
    int  first;
    bit  idle_ok;
    exp4  = '{8'hFC, 8'hF8, 8'hF0};
    modes = '{MODE_X1, MODE_X2, MODE_X4};

    reset_n       = 1'b0;
    set_ab(2'b11);
    bus0.mode     = MODE_X4;
    bus0.load     = '0;
    bus0.load_val = '0;
    bus0.clr_err  = '0;
    wait_clk(3);
    reset_n = 1'b1;

    // 1: inputs at 11 through reset release -> stays idle
    idle_ok = 1;
    for (int k = 0; k < 20; k++) begin
      wait_clk(1);
      if (bus0.step !== 4'h0 || bus0.pos !== 32'h0) idle_ok = 0;
    end
    chk("reset_idle", 64'(idle_ok), 64'd1);

    // 2: reach 00 legally, zero, then one forward cycle
    set_ab(2'b10); wait_clk(10);
    set_ab(2'b00); wait_clk(10);
    load_all(8'h00);
    stepcnt = 0;
    first   = 0;
    set_ab(2'b10);
    for (int k = 1; k <= 10; k++) begin
      wait_clk(1);
      if (bus0.step[0] === 1'b1 && first == 0) first = k;
    end
    chk("step_latency", 64'(first), 64'd8);
    set_ab(2'b11); wait_clk(10);
    set_ab(2'b01); wait_clk(10);
    set_ab(2'b00); wait_clk(10);
    chk("fwd_pos_all", 64'(bus0.pos), 64'h04040404);
    chk("fwd_steps", 64'(stepcnt), 64'd4);
    chk("fwd_dir", 64'(bus0.dir[0]), 64'd1);

    // 3: glitch rejection at the filter boundary
    stepcnt = 0;
    set_ab(2'b10); wait_clk(3);
    set_ab(2'b00); wait_clk(12);
    chk("glitch_short", 64'(stepcnt), 64'd0);
    set_ab(2'b10); wait_clk(4);
    set_ab(2'b00); wait_clk(3);
    set_ab(2'b10); wait_clk(12);
    chk("glitch_held", 64'(stepcnt), 64'd1);
    set_ab(2'b00); wait_clk(12);

    // 4: four reverse cycles per decode mode
    for (int m = 0; m < 3; m++) begin
      bus0.mode = modes[m];
      load_all(8'h00);
      for (int c = 0; c < 4; c++) begin
        set_ab(2'b01); wait_clk(6);
        set_ab(2'b11); wait_clk(6);
        set_ab(2'b10); wait_clk(6);
        set_ab(2'b00); wait_clk(6);
      end
      wait_clk(10);
      chk("mode_rev_pos", 64'(bus0.pos[W-1:0]), 64'(exp4[m]));
    end

    // 5: illegal transitions and err clearing
    set_ab(2'b11); wait_clk(12);
    chk("illegal_err", 64'(bus0.err[0]), 64'd1);
    chk("illegal_pos", 64'(bus0.pos[W-1:0]), 64'hF0);
    set_ab(2'b00); wait_clk(7);
    bus0.clr_err = '1; wait_clk(1);
    bus0.clr_err = '0;
    chk("err_set_wins", 64'(bus0.err[0]), 64'd1);
    wait_clk(5);
    bus0.clr_err = '1; wait_clk(1);
    bus0.clr_err = '0;
    chk("err_cleared", 64'(bus0.err[0]), 64'd0);

    // 6: wrap vs saturate at +127, then load against a coincident step
    load_all(8'h7F);
    set_ab(2'b10); wait_clk(12);
    chk("wrap_127p1", 64'(bus0.pos[W-1:0]), 64'h80);
    chk("sat_127p1", 64'(bus1.pos[W-1:0]), 64'h7F);
    chk("sat_dir", 64'(bus1.dir[0]), 64'd1);
    set_ab(2'b11); wait_clk(7);
    bus0.load_val = 8'h55;
    bus0.load     = '1;
    wait_clk(1);
    bus0.load     = '0;
    chk("load_vs_step_step", 64'(bus0.step[0]), 64'd0);
    chk("load_vs_step_pos", 64'(bus0.pos[W-1:0]), 64'h55);
    wait_clk(10);

    // random traffic with a mid-run reset
    for (int ch = 0; ch < N; ch++) begin
      ph_r[ch] = 2;
      hold[ch] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (hold[ch] == 0) begin
          int r;
          r = $urandom_range(0, 19);
          ph_r[ch] = (ph_r[ch] + ((r < 9) ? 1 : ((r < 18) ? 3 : 2))) % 4;
          hold[ch] = $urandom_range(1, 12);
          case (ph_r[ch])
            0:       begin bus0.enc_a[ch] = 1'b0; bus0.enc_b[ch] = 1'b0; end
            1:       begin bus0.enc_a[ch] = 1'b1; bus0.enc_b[ch] = 1'b0; end
            2:       begin bus0.enc_a[ch] = 1'b1; bus0.enc_b[ch] = 1'b1; end
            default: begin bus0.enc_a[ch] = 1'b0; bus0.enc_b[ch] = 1'b1; end
          endcase
        end else begin
          hold[ch]--;
        end
        bus0.load[ch]    = ($urandom_range(0, 63) == 0);
        bus0.clr_err[ch] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 199) == 0) bus0.mode = mode_t'($urandom_range(0, 3));
      bus0.load_val = W'($urandom);
      reset_n = !(cyc >= 1500 && cyc < 1503);
      wait_clk(1);
    end
    bus0.load    = '0;
    bus0.clr_err = '0;
    reset_n      = 1'b1;
    wait_clk(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
